// File: rtl/control_unit.sv
// Multi-cycle processor control FSM: fetch, decode, load/store, ALU and conditional branch.
// Overflow branches (BOV/BNOV/BUOV/BNUOV) are enabled by defining CONTROL_UNIT_OVF_BRANCH_EN.

package k_and_s_pkg;
    typedef enum logic [4:0] {
        InstrNop    = 5'd0,
        InstrLoad   = 5'd1,
        InstrStore  = 5'd2,
        InstrMove   = 5'd3,
        InstrAdd    = 5'd4,
        InstrSub    = 5'd5,
        InstrAnd    = 5'd6,
        InstrOr     = 5'd7,
        InstrBranch = 5'd8,
        InstrBzero  = 5'd9,
        InstrBnzero = 5'd10,
        InstrBneg   = 5'd11,
        InstrBnneg  = 5'd12,
        InstrBov    = 5'd13,
        InstrBnov   = 5'd14,
        InstrBuov   = 5'd15,
        InstrBnuov  = 5'd16,
        InstrHalt   = 5'd17
    } decoded_instruction_type;
endpackage

module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StLoad1, StLoad2, StStore1, StExecAlu, StExecBranch, StHalted
    } state_t;

    state_t                  state_q, state_d;
    logic                    run_q;
    logic                    pc_inc_q;
    logic                    in_branch_q;
    decoded_instruction_type branch_sel_q;
    logic                    cond_true;

    always_comb begin
        state_d = state_q;
        case (state_q)
            // One settle cycle after reset release before the first fetch.
            StIdle:   if (run_q) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (decoded_instruction)
                    InstrLoad:  state_d = StLoad1;
                    InstrStore: state_d = StStore1;
                    InstrMove, InstrAdd, InstrSub, InstrAnd, InstrOr: state_d = StExecAlu;
                    InstrBranch, InstrBzero, InstrBnzero, InstrBneg, InstrBnneg:
                        state_d = StExecBranch;
`ifdef CONTROL_UNIT_OVF_BRANCH_EN
                    InstrBov, InstrBnov, InstrBuov, InstrBnuov: state_d = StExecBranch;
`endif
                    InstrHalt:  state_d = StHalted;
                    default:    state_d = StFetch;
                endcase
            end
            StLoad1:  state_d = StLoad2;
            StLoad2, StStore1, StExecAlu, StExecBranch: state_d = StFetch;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            run_q            <= 1'b0;
            pc_inc_q         <= 1'b0;
            in_branch_q      <= 1'b0;
            branch_sel_q     <= InstrNop;
            ir_enable        <= 1'b0;
            addr_sel         <= 1'b0;
            c_sel            <= 1'b0;
            operation        <= 2'b00;
            write_reg_enable <= 1'b0;
            flags_reg_enable <= 1'b0;
            ram_write_enable <= 1'b0;
            halt             <= 1'b0;
        end else begin
            state_q          <= state_d;
            run_q            <= 1'b1;
            pc_inc_q         <= 1'b0;
            in_branch_q      <= 1'b0;
            ir_enable        <= 1'b0;
            addr_sel         <= 1'b0;
            c_sel            <= 1'b0;
            operation        <= 2'b00;
            write_reg_enable <= 1'b0;
            flags_reg_enable <= 1'b0;
            ram_write_enable <= 1'b0;
            halt             <= 1'b0;
            case (state_d)
                StFetch:  ir_enable <= 1'b1;
                StDecode: pc_inc_q  <= 1'b1;
                StLoad1:  addr_sel  <= 1'b1;
                StLoad2: begin
                    addr_sel         <= 1'b1;
                    c_sel            <= 1'b1;
                    write_reg_enable <= 1'b1;
                end
                StStore1: begin
                    addr_sel         <= 1'b1;
                    ram_write_enable <= 1'b1;
                end
                StExecAlu: begin
                    write_reg_enable <= 1'b1;
                    flags_reg_enable <= (decoded_instruction != InstrMove);
                    case (decoded_instruction)
                        InstrSub:          operation <= 2'b01;
                        InstrAnd:          operation <= 2'b10;
                        InstrOr, InstrMove: operation <= 2'b11;
                        default:           operation <= 2'b00;
                    endcase
                end
                StExecBranch: begin
                    in_branch_q  <= 1'b1;
                    branch_sel_q <= decoded_instruction;
                end
                StHalted: halt <= 1'b1;
                default: ;
            endcase
        end
    end

    // Flags are evaluated live in the branch cycle so a preceding ALU result is visible.
    always_comb begin
        cond_true = 1'b0;
        case (branch_sel_q)
            InstrBranch: cond_true = 1'b1;
            InstrBzero:  cond_true = zero_op;
            InstrBnzero: cond_true = !zero_op;
            InstrBneg:   cond_true = neg_op;
            InstrBnneg:  cond_true = !neg_op;
`ifdef CONTROL_UNIT_OVF_BRANCH_EN
            InstrBov:    cond_true = signed_overflow;
            InstrBnov:   cond_true = !signed_overflow;
            InstrBuov:   cond_true = unsigned_overflow;
            InstrBnuov:  cond_true = !unsigned_overflow;
`endif
            default:     cond_true = 1'b0;
        endcase
    end

`ifndef CONTROL_UNIT_OVF_BRANCH_EN
    logic unused_ovf;
    assign unused_ovf = signed_overflow ^ unsigned_overflow;
`endif

    assign branch    = in_branch_q & cond_true;
    assign pc_enable = pc_inc_q | branch;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit; honours CONTROL_UNIT_OVF_BRANCH_EN like the DUT.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    decoded_instruction_type decoded_instruction = InstrNop;
    logic zero_op = 1'b0, neg_op = 1'b0, unsigned_overflow = 1'b0, signed_overflow = 1'b0;
    logic branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable;
    logic ram_write_enable, halt;
    logic [1:0] operation;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
        .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
        .ram_write_enable(ram_write_enable), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    // Output vector: {branch, pc_en, ir_en, addr_sel, c_sel, wr_reg, flags_en, op[1:0], ram_we, halt}
    function automatic logic [10:0] mk(bit br, bit pc, bit ir, bit as, bit cs, bit wr, bit fl,
                                       logic [1:0] op, bit rw, bit h);
        return {br, pc, ir, as, cs, wr, fl, op, rw, h};
    endfunction

    function automatic bit ovf_en();
`ifdef CONTROL_UNIT_OVF_BRANCH_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // 0 nop, 1 load, 2 store, 3 alu, 4 branch, 5 halt
    function automatic int kind(decoded_instruction_type c);
        case (c)
            InstrLoad:  return 1;
            InstrStore: return 2;
            InstrMove, InstrAdd, InstrSub, InstrAnd, InstrOr: return 3;
            InstrBranch, InstrBzero, InstrBnzero, InstrBneg, InstrBnneg: return 4;
            InstrBov, InstrBnov, InstrBuov, InstrBnuov: return ovf_en() ? 4 : 0;
            InstrHalt:  return 5;
            default:    return 0;
        endcase
    endfunction

    function automatic bit taken(decoded_instruction_type c, logic [3:0] f);
        // f = {zero, neg, signed_ovf, unsigned_ovf}
        case (c)
            InstrBranch: return 1'b1;
            InstrBzero:  return f[3];
            InstrBnzero: return !f[3];
            InstrBneg:   return f[2];
            InstrBnneg:  return !f[2];
            InstrBov:    return f[1];
            InstrBnov:   return !f[1];
            InstrBuov:   return f[0];
            InstrBnuov:  return !f[0];
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_op(decoded_instruction_type c);
        case (c)
            InstrSub:           return 2'b01;
            InstrAnd:           return 2'b10;
            InstrOr, InstrMove: return 2'b11;
            default:            return 2'b00;
        endcase
    endfunction

    function automatic decoded_instruction_type rand_code();
        int r;
        r = $urandom_range(0, 20);
        if (r >= 17) r = r + 3;  // skip HALT, include a few undefined encodings
        return decoded_instruction_type'(5'(r));
    endfunction

    task automatic push(input logic [10:0] v, input string tag);
        exp_t e;
        e.v = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    // One cycle: drive instruction and flags at the falling edge (fl < 0 means random flags).
    task automatic tick(input decoded_instruction_type c, input int fl);
        @(negedge clk);
        decoded_instruction = c;
        if (fl < 0) {zero_op, neg_op, signed_overflow, unsigned_overflow} = 4'($urandom);
        else {zero_op, neg_op, signed_overflow, unsigned_overflow} = 4'(fl);
    endtask

    task automatic run_instr(input decoded_instruction_type c, input int fl);
        int k;
        k = kind(c);
        tick(c, -1);
        push(mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), "fetch");
        tick(c, -1);
        push(mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "decode");
        case (k)
            1: begin
                tick(c, -1);
                push(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0), "load1");
                tick(c, -1);
                push(mk(0, 0, 0, 1, 1, 1, 0, 2'b00, 0, 0), "load2");
            end
            2: begin
                tick(c, -1);
                push(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0), "store1");
            end
            3: begin
                tick(c, -1);
                push(mk(0, 0, 0, 0, 0, 1, c != InstrMove, alu_op(c), 0, 0), "exec_alu");
            end
            4: begin
                bit t;
                tick(c, fl);
                t = taken(c, {zero_op, neg_op, signed_overflow, unsigned_overflow});
                push(mk(t, t, 0, 0, 0, 0, 0, 2'b00, 0, 0), "exec_branch");
            end
            5: begin
                for (int i = 0; i < 20; i++) begin
                    tick(rand_code(), -1);
                    push(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), "halted");
                end
            end
            default: ;
        endcase
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            decoded_instruction = rand_code();
            push(11'd0, "in_reset");
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push(11'd0, "idle_a");
        tick(InstrNop, -1);
        push(11'd0, "idle_b");
    endtask

    initial begin : monitor
        exp_t e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable,
                       flags_reg_enable, operation, ram_write_enable, halt};
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %b expected %b", e.tag, $time, act, e.v);
                end
            end
        end
    end

    initial begin : driver
        hold_reset(3);
        release_reset();
        run_instr(InstrNop, -1);
        run_instr(InstrLoad, -1);
        run_instr(InstrSub, -1);
        run_instr(InstrBzero, 4'b1000);
        run_instr(InstrSub, -1);
        run_instr(InstrBzero, 4'b0000);
        run_instr(InstrBov, 4'b0010);
        run_instr(InstrBnuov, 4'b0001);
        run_instr(InstrMove, -1);
        run_instr(InstrStore, -1);
        for (int i = 0; i < 200; i++) run_instr(rand_code(), -1);
        run_instr(InstrHalt, -1);

        // Reset mid-LOAD_1: outputs must clear without waiting for a clock edge.
        hold_reset(2);
        release_reset();
        tick(InstrLoad, -1);
        push(mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), "fetch");
        tick(InstrLoad, -1);
        push(mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "decode");
        @(negedge clk);
        rst_n = 1'b0;
        push(11'd0, "reset_mid_load1");
        hold_reset(1);
        release_reset();
        for (int i = 0; i < 60; i++) run_instr(rand_code(), -1);

        repeat (3) @(negedge clk);
        #4;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: decoded_instruction  input  decoded_instruction_type (k_and_s_pkg)  instruction currently held in IR.
REQ-004 SHALL have ports: zero_op, neg_op, unsigned_overflow, signed_overflow  input  1 each  registered flags from data path.
REQ-005 SHALL have ports: branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  output  1 each  data-path controls.
REQ-006 SHALL have port: operation  output  2  ALU select; 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 SHALL have port: ram_write_enable  output  1  RAM write strobe.
REQ-008 SHALL have port: halt  output  1  processor stopped.

Function
REQ-009 SHALL be a Moore FSM; every output is decoded from current state only; an output not listed for a state is 0; operation is 00 unless listed.
REQ-010 SHALL implement states IDLE, FETCH, DECODE, LOAD_1, LOAD_2, STORE_1, EXEC_ALU, EXEC_BRANCH, HALTED.
REQ-011 SHALL go IDLE -> FETCH unconditionally; IDLE drives all outputs 0.
REQ-012 FETCH: ir_enable=1, addr_sel=0; next DECODE.
REQ-013 DECODE: pc_enable=1, branch=0 (PC+1); next: LOAD->LOAD_1, STORE->STORE_1, MOVE/ADD/SUB/AND/OR->EXEC_ALU, BRANCH/BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV/BUOV/BNUOV->EXEC_BRANCH, HALT->HALTED, NOP or unknown->FETCH.
REQ-014 LOAD_1: addr_sel=1; next LOAD_2. LOAD_2: addr_sel=1, c_sel=1, write_reg_enable=1; next FETCH.
REQ-015 STORE_1: addr_sel=1, ram_write_enable=1; next FETCH.
REQ-016 EXEC_ALU: c_sel=0, write_reg_enable=1; operation per instruction (MOVE drives 11, data path forces B=A); flags_reg_enable=1 except MOVE (0); next FETCH.
REQ-017 EXEC_BRANCH: branch=1, pc_enable=1 when condition true (BRANCH always; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op; BOV signed_overflow; BNOV !signed_overflow; BUOV unsigned_overflow; BNUOV !unsigned_overflow), else both 0; next FETCH.
REQ-018 Branch condition SHALL sample flags in EXEC_BRANCH cycle; flags written by preceding ALU instruction are therefore visible.
REQ-019 HALTED: halt=1, all other outputs 0; remains until reset.
REQ-020 Instruction latency SHALL be: NOP 2, STORE/ALU/branch 3, LOAD 4 cycles from FETCH entry.
REQ-021 pc_enable, ir_enable, write_reg_enable, ram_write_enable SHALL never be asserted simultaneously in one state except as listed.

Reset
REQ-022 rst_n low SHALL force state IDLE immediately, asynchronously, including mid-instruction; all outputs 0 while low.
REQ-023 First FETCH SHALL occur on the second rising edge after rst_n deasserts.

Configuration
REQ-024 Macro CONTROL_UNIT_OVF_BRANCH_EN defined: BOV, BNOV, BUOV, BNUOV handled per REQ-017.
REQ-025 Macro CONTROL_UNIT_OVF_BRANCH_EN undefined: those four decode as NOP (DECODE->FETCH), never assert branch.

Verification
REQ-026 Reset release, decoded_instruction=NOP -> IDLE, FETCH(ir_enable=1), DECODE(pc_enable=1), FETCH; halt=0.
REQ-027 LOAD -> LOAD_1 addr_sel=1; LOAD_2 addr_sel=1, c_sel=1, write_reg_enable=1; back to FETCH after 4 cycles.
REQ-028 SUB then BZERO with zero_op=1 -> EXEC_ALU operation=01, flags_reg_enable=1; EXEC_BRANCH branch=1, pc_enable=1; zero_op=0 -> both 0.
REQ-029 BOV with signed_overflow=1: macro defined -> branch=1; undefined -> DECODE->FETCH, branch never 1.
REQ-030 HALT -> halt=1 held 20 cycles; rst_n pulsed low mid-LOAD_1 -> immediate IDLE, all outputs 0.
